uart_tx_engine: RTL and testbench
=================================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter BITWIDTH, default 8, data and baud-value width.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two).
REQ-003 pclk  in  1  single clock for the block; all state changes on rising edge.
REQ-004 preset  in  1  reset, asynchronous assert, active-high; synchronously released.
REQ-005 data_in  in  BITWIDTH  byte to transmit, from APB slave data register.
REQ-006 wr_en  in  1  one-cycle write strobe; pushes data_in into FIFO.
REQ-007 baud_val  in  BITWIDTH  baud divisor from APB slave baud register.
REQ-008 tx_en  in  1  transmit enable; 0 holds frames in FIFO.
REQ-009 par_en  in  1  parity bit inserted when 1.
REQ-010 par_odd  in  1  1 = odd parity, 0 = even parity.
REQ-011 tx  out  1  serial line, idle high.
REQ-012 tf_TXRDY  out  1  FIFO not full; feeds APB slave TX_RDY.
REQ-013 tx_busy  out  1  frame in progress (state not IDLE).
REQ-014 overflow  out  1  one-cycle pulse when a write is dropped.

Function
REQ-015 Baud tick SHALL assert for one cycle every (baud_q+1) pclk cycles; baud_q = baud_val latched at frame start.
REQ-016 Each serial bit SHALL last exactly 16 baud ticks, i.e. 16*(baud_q+1) pclk cycles; baud_val=0 gives 16 cycles/bit.
REQ-017 States: IDLE, START, DATA, PARITY, STOP; encoding in shared package.
REQ-018 IDLE -> START when tx_en=1 and FIFO non-empty; pop, latch byte and baud_val in that cycle; tx goes 0 on next cycle; tick counter cleared.
REQ-019 START -> DATA after one bit time; DATA shifts BITWIDTH bits LSB first.
REQ-020 DATA -> PARITY if par_en=1, else -> STOP; parity bit = XOR of data bits XOR par_odd, par_en/par_odd latched at frame start.
REQ-021 STOP drives tx=1 for one bit time, then -> IDLE; back-to-back frame starts the cycle after STOP ends if FIFO non-empty.
REQ-022 tx_en deasserted mid-frame SHALL NOT abort current frame; only prevents the next pop.
REQ-023 baud_val changes mid-frame SHALL NOT affect current frame.
REQ-024 wr_en with FIFO full and no pop same cycle: data discarded, overflow pulses 1 cycle, FIFO unchanged.
REQ-025 wr_en with FIFO full and pop same cycle: write accepted, no overflow.
REQ-026 wr_en with FIFO empty and IDLE, tx_en=1: push this cycle, pop next cycle (no bypass); tx low two cycles after wr_en.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-028 tf_TXRDY = (count != FIFO_DEPTH), registered-state derived, no combinational path from wr_en.

Reset
REQ-029 On preset: state IDLE, tx=1, tx_busy=0, overflow=0, tf_TXRDY=1, FIFO empty, tick/bit counters 0, latched byte 0.
REQ-030 Reset mid-frame SHALL force tx=1 asynchronously; partial frame abandoned, FIFO contents lost.

Structure
REQ-031 Shared package uart_pkg: state enum, oversample constant 16, default BITWIDTH.
REQ-032 FIFO SHALL be sub-module uart_tx_fifo (push, pop, dout, full, empty, count); baud/shift/FSM logic in uart_tx_engine.

Verification
REQ-033 baud_val=0, par_en=0, write 0x55 -> tx: 0 for 16 cycles, then 1,0,1,0,1,0,1,0 each 16 cycles, stop 1 for 16; frame 160 cycles; tx_busy high throughout.
REQ-034 baud_val=3, par_en=1, par_odd=0, write 0x07 -> each bit 64 cycles; parity bit=1; frame 11 bits = 704 cycles.
REQ-035 tx_en=0, 5 back-to-back writes 0x01..0x05 -> tf_TXRDY low after 4th; overflow pulse on 5th; tx_en=1 then sends 0x01..0x04 only, back-to-back, no idle gap.
REQ-036 FIFO full, tx_en=1, write same cycle as pop -> no overflow, count stays 4, written byte transmitted last.
REQ-037 Assert preset during DATA bit 3 of 0xA5 -> tx=1 same cycle, tf_TXRDY=1, tx_busy=0; after release, new write 0x3C transmits cleanly.
REQ-038 Change baud_val 0->7 mid-frame -> current frame keeps 16 cycles/bit; next frame 128 cycles/bit.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit engine and its FIFO.
//   tx_state_t        - transmit FSM state encoding (also exported as debug state)
//   OVERSAMPLE        - baud ticks per serial bit
//   OS_CNT_W          - width of the per-bit tick counter
//   DEFAULT_BITWIDTH  - default data / baud-divisor width
package uart_pkg;

    localparam int DEFAULT_BITWIDTH = 8;
    localparam int OVERSAMPLE       = 16;
    localparam int OS_CNT_W         = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit holding FIFO, DEPTH entries (power of two, >= 2).
//   clk, rst      - clock, asynchronous active-high reset (empties the FIFO)
//   push, din     - write request and data; taken when not full, or when full
//                   and a pop happens in the same cycle
//   pop, dout     - read request (ignored when empty); dout shows the head entry
//   full, empty   - occupancy flags derived from the registered count
//   count         - number of stored entries, 0..DEPTH
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem[rd_ptr];

    assign do_pop  = pop && !empty;
    // A pop frees the slot this same cycle, so a write into a full FIFO is
    // still taken when it coincides with a pop.
    assign do_push = push && (!full || do_pop);

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
    // modulo DEPTH by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: FIFO-buffered UART transmitter with baud divider,
// 16x oversampled bit timing and optional odd/even parity.
//   pclk, preset  - clock; asynchronous active-high reset (released synchronously upstream)
//   data_in/wr_en - byte to queue and its one-cycle write strobe
//   baud_val      - baud divisor; one baud tick every baud_val+1 cycles
//   tx_en         - allows the next frame to start (never aborts a frame)
//   par_en/par_odd- parity insertion and polarity
//   tx            - serial line, idle high
//   tf_TXRDY      - FIFO not full
//   tx_busy       - a frame is on the line
//   overflow      - one-cycle pulse when a write is dropped
//   state_dbg     - current FSM state (uart_pkg::tx_state_t encoding)
//
// Write handshake: wr_en is a one-cycle push with no back-pressure. It is
// accepted when tf_TXRDY=1, or when the FIFO is full but the engine pops in
// the same cycle; otherwise the byte is dropped and overflow pulses in that
// cycle.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int BITWIDTH   = DEFAULT_BITWIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic [BITWIDTH-1:0] data_in,
    input  logic                wr_en,
    input  logic [BITWIDTH-1:0] baud_val,
    input  logic                tx_en,
    input  logic                par_en,
    input  logic                par_odd,
    output logic                tx,
    output logic                tf_TXRDY,
    output logic                tx_busy,
    output logic                overflow,
    output logic [2:0]          state_dbg
);

    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_CNT_W = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BITWIDTH - 1);
    localparam logic [OS_CNT_W-1:0]  OS_LAST  = OS_CNT_W'(OVERSAMPLE - 1);

    tx_state_t             state_q;
    tx_state_t             state_d;
    logic                  start_frame;

    logic [BITWIDTH-1:0]   fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    logic [BITWIDTH-1:0]   shift_q;
    logic [BITWIDTH-1:0]   baud_q;
    logic [BITWIDTH-1:0]   tick_cnt_q;
    logic [OS_CNT_W-1:0]   os_cnt_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic                  par_en_q;
    logic                  par_bit_q;

    logic                  baud_tick;
    logic                  bit_done;

    uart_tx_fifo #(
        .WIDTH (BITWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (pclk),
        .rst   (preset),
        .push  (wr_en),
        .din   (data_in),
        .pop   (start_frame),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tf_TXRDY  = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign overflow  = wr_en && fifo_full && !start_frame;
    assign tx_busy   = (state_q != ST_IDLE);
    assign state_dbg = state_q;

    assign baud_tick = (tick_cnt_q == baud_q);
    assign bit_done  = baud_tick && (os_cnt_q == OS_LAST);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // start_frame doubles as the FIFO pop. From STOP it chains straight into
    // the next START so queued frames leave with no idle gap on the line.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    start_frame = 1'b1;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done && (bit_cnt_q == LAST_BIT))
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_done) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (tx_en && !fifo_empty) begin
                        start_frame = 1'b1;
                        state_d     = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte, divisor and parity settings are captured at frame start so that
    // register writes during a frame only affect the next one.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            shift_q    <= '0;
            baud_q     <= '0;
            tick_cnt_q <= '0;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
        end else if (start_frame) begin
            shift_q    <= fifo_dout;
            baud_q     <= baud_val;
            par_en_q   <= par_en;
            par_bit_q  <= (^fifo_dout) ^ par_odd;
            tick_cnt_q <= '0;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
        end else if (state_q != ST_IDLE) begin
            if (baud_tick) begin
                tick_cnt_q <= '0;
                os_cnt_q   <= os_cnt_q + 1'b1;
            end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
            end
            if (bit_done && (state_q == ST_DATA)) begin
                shift_q   <= shift_q >> 1;
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

    // Line level decodes the registered state, so reset drives it high at once.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shift_q[0];
            ST_PARITY: tx = par_bit_q;
            default:   tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: scoreboard bench for uart_tx_engine.
// Each accepted write pushes a frame record {b2b, par_odd, par_en, baud, data}
// into exp_q; the monitor decodes the tx line, pops a record at every start
// bit and compares the whole waveform cycle by cycle against the frame the
// record describes.
module tb_uart_tx_engine;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int REC_W = 2*W + 3;

    logic         pclk;
    logic         preset;
    logic [W-1:0] data_in;
    logic         wr_en;
    logic [W-1:0] baud_val;
    logic         tx_en;
    logic         par_en;
    logic         par_odd;
    logic         tx;
    logic         tf_TXRDY;
    logic         tx_busy;
    logic         overflow;
    logic [2:0]   state_dbg;

    logic [REC_W-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int idle_cycles = 0;

    uart_tx_engine #(
        .BITWIDTH   (W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .data_in   (data_in),
        .wr_en     (wr_en),
        .baud_val  (baud_val),
        .tx_en     (tx_en),
        .par_en    (par_en),
        .par_odd   (par_odd),
        .tx        (tx),
        .tf_TXRDY  (tf_TXRDY),
        .tx_busy   (tx_busy),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at 100000 cycles, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic cycle();
        @(posedge pclk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic write_byte(input logic [W-1:0] d, input logic exp_ovf);
        data_in = d;
        wr_en   = 1'b1;
        #3;
        check("overflow", overflow, exp_ovf);
        cycle();
        wr_en   = 1'b0;
    endtask

    // Records the frame this byte must produce, using the config that will be
    // live when the byte is popped, then writes it.
    task automatic send(input logic [W-1:0] d, input logic b2b);
        exp_q.push_back({b2b, par_odd, par_en, baud_val, d});
        write_byte(d, 1'b0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_within_budget", (n < budget), 1);
        cycles(3);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [REC_W-1:0] rec;
        logic [W-1:0]     d;
        logic [W-1:0]     b;
        logic             pe;
        logic             po;
        logic             b2b;
        logic             lvl [W+3];
        int               nbits;
        int               bitlen;
        int               cyc;
        int               bad_cyc;
        logic             bad_tx;
        logic             bad_busy;
        logic             want_tx;
        bit               ok;
        bit               aborted;
        bit               just_ended;
        just_ended = 1'b0;
        forever begin
            @(negedge pclk);
            if (preset) begin
                just_ended = 1'b0;
                continue;
            end
            if (just_ended) begin
                check("post_frame_busy", tx_busy,
                      (exp_q.size() > 0) ? 32'(exp_q[0][REC_W-1]) : 32'd0);
                just_ended = 1'b0;
            end
            if (tx !== 1'b0) begin
                idle_cycles++;
                continue;
            end
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_frame: got start bit, required idle line");
                for (int k = 0; k < 100000 && tx !== 1'b1; k++) @(negedge pclk);
                continue;
            end
            rec = exp_q.pop_front();
            d   = rec[W-1:0];
            b   = rec[2*W-1:W];
            pe  = rec[2*W];
            po  = rec[2*W+1];
            b2b = rec[2*W+2];
            if (b2b) check("b2b_gap", idle_cycles, 0);

            // Reference frame: start 0, data LSB first, optional parity, stop 1.
            nbits  = pe ? W + 3 : W + 2;
            bitlen = 16 * (int'(b) + 1);
            lvl[0] = 1'b0;
            for (int i = 0; i < W; i++) lvl[i+1] = d[i];
            if (pe) lvl[W+1] = (($countones(d) % 2) == 1) ^ po;
            lvl[nbits-1] = 1'b1;

            ok       = 1'b1;
            aborted  = 1'b0;
            cyc      = 0;
            bad_cyc  = 0;
            bad_tx   = 1'b0;
            bad_busy = 1'b0;
            want_tx  = 1'b0;
            for (int bi = 0; bi < nbits && !aborted; bi++) begin
                for (int c = 0; c < bitlen && !aborted; c++) begin
                    if (cyc != 0) @(negedge pclk);
                    if (preset) begin
                        aborted = 1'b1;
                    end else begin
                        if (ok && (tx !== lvl[bi] || tx_busy !== 1'b1)) begin
                            ok       = 1'b0;
                            bad_cyc  = cyc;
                            bad_tx   = tx;
                            bad_busy = tx_busy;
                            want_tx  = lvl[bi];
                        end
                        cyc++;
                    end
                end
            end
            if (!aborted) begin
                vectors++;
                if (!ok) begin
                    miscompares++;
                    $display("FAIL frame_%02h: cycle %0d got tx=%b busy=%b required tx=%b busy=1",
                             d, bad_cyc, bad_tx, bad_busy, want_tx);
                end
            end
            idle_cycles = 0;
            just_ended  = !aborted;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        preset   = 1'b1;
        data_in  = '0;
        wr_en    = 1'b0;
        baud_val = '0;
        tx_en    = 1'b0;
        par_en   = 1'b0;
        par_odd  = 1'b0;

        // Reset state, while held and after release.
        cycles(3);
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_txrdy", tf_TXRDY, 1);
        check("rst_overflow", overflow, 0);
        check("rst_state", state_dbg, 0);
        preset = 1'b0;
        cycles(2);
        check("post_rst_tx", tx, 1);
        check("post_rst_busy", tx_busy, 0);

        // 0x55 at 16 cycles/bit, no parity; tx low two cycles after wr_en.
        tx_en = 1'b1;
        send(8'h55, 1'b0);
        check("lat_pop_cycle_tx", tx, 1);
        cycle();
        check("lat_start_tx", tx, 0);
        check("lat_start_busy", tx_busy, 1);
        wait_idle(400);

        // 0x07 at 64 cycles/bit with even parity (parity bit 1).
        baud_val = 8'd3;
        par_en   = 1'b1;
        par_odd  = 1'b0;
        send(8'h07, 1'b0);
        wait_idle(1000);

        // tx_en=0: fill the FIFO, fifth write overflows, then release.
        baud_val = 8'd0;
        par_en   = 1'b0;
        tx_en    = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), (i != 1));
            check("fill_txrdy", tf_TXRDY, (i < 4) ? 1 : 0);
        end
        write_byte(8'h05, 1'b1);
        check("after_ovf_txrdy", tf_TXRDY, 0);
        cycles(20);
        check("held_tx", tx, 1);
        check("held_busy", tx_busy, 0);
        tx_en = 1'b1;
        wait_idle(1200);
        check("drained_txrdy", tf_TXRDY, 1);

        // Full FIFO, write in the same cycle as the first pop: accepted.
        tx_en = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), (i != 0));
        tx_en = 1'b1;
        send(8'h99, 1'b1);
        check("wr_on_pop_txrdy", tf_TXRDY, 0);
        wait_idle(1500);

        // Reset during data bit 3 of 0xA5 with 0xEE queued behind it.
        send(8'hA5, 1'b0);
        send(8'hEE, 1'b1);
        cycles(70);
        check("pre_rst_tx_bit3", tx, 0);
        check("pre_rst_busy", tx_busy, 1);
        preset = 1'b1;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", tx_busy, 0);
        check("async_rst_txrdy", tf_TXRDY, 1);
        exp_q.delete();
        cycles(3);
        preset = 1'b0;
        cycles(5);
        check("rst_flush_busy", tx_busy, 0);
        send(8'h3C, 1'b0);
        wait_idle(400);

        // baud_val 0 -> 7 during a frame: next queued frame picks up 7.
        baud_val = 8'd0;
        send(8'h5A, 1'b0);
        cycles(10);
        baud_val = 8'd7;
        send(8'hC3, 1'b1);
        wait_idle(2000);

        // Randomized bursts with random parity and divisor.
        for (int it = 0; it < 6; it++) begin
            int n;
            baud_val = 8'($urandom_range(0, 2));
            par_en   = 1'($urandom_range(0, 1));
            par_odd  = 1'($urandom_range(0, 1));
            n        = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) send(8'($urandom_range(0, 255)), (j != 0));
            wait_idle(3000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
